// File: rtl/sip_shift_acc_pkg.sv
// Shared widths, precision codes, FSM encoding and job configuration for the SIP shift-accumulate stage.
// Holds declarations only; it adds no latency and has no flow control.
package sip_shift_acc_pkg;

    localparam int BITS_SIP_DOT_ADDER = 10;
    localparam int BITS_ACC           = 32;
    localparam int BITS_CHUNK_IDX     = 2;

    localparam logic [1:0] PREC_2B = 2'd0;
    localparam logic [1:0] PREC_4B = 2'd1;
    localparam logic [1:0] PREC_8B = 2'd2;

    typedef logic [BITS_CHUNK_IDX-1:0] idx_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        idx_t last_a;
        idx_t last_w;
        logic signed_a;
        logic signed_w;
    } job_cfg_t;

    // Index of the last 2-bit chunk; the reserved code 3 behaves as 8b.
    function automatic idx_t prec_last_idx(input logic [1:0] prec);
        case (prec)
            PREC_2B: return idx_t'(0);
            PREC_4B: return idx_t'(1);
            default: return idx_t'(3);
        endcase
    endfunction

endpackage

// File: rtl/sip_step_ctr.sv
// Nested chunk-pair counter (ia inner, iw outer) with last-step detect and dot-stage sign flags.
// Latency: indices move one step per cycle on adv; adv low holds every index and flag.
module sip_step_ctr
    import sip_shift_acc_pkg::*;
(
    input  logic     core_clk,
    input  logic     arst_n,
    input  logic     load,
    input  job_cfg_t cfg,
    input  logic     run,
    input  logic     adv,
    output idx_t     ia,
    output idx_t     iw,
    output logic     last,
    output logic     sign_i,
    output logic     sign_w
);

    job_cfg_t cfg_q;
    idx_t     ia_q;
    idx_t     iw_q;
    logic     a_end;
    logic     w_end;

    assign a_end = (ia_q == cfg_q.last_a);
    assign w_end = (iw_q == cfg_q.last_w);

    // The final advance wraps both indices to 0, so DONE/IDLE already see zeros.
    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            cfg_q <= '0;
            ia_q  <= '0;
            iw_q  <= '0;
        end else if (load) begin
            cfg_q <= cfg;
            ia_q  <= '0;
            iw_q  <= '0;
        end else if (adv) begin
            if (a_end) begin
                ia_q <= '0;
                iw_q <= w_end ? '0 : iw_q + idx_t'(1);
            end else begin
                ia_q <= ia_q + idx_t'(1);
            end
        end
    end

    assign ia     = run ? ia_q : '0;
    assign iw     = run ? iw_q : '0;
    assign last   = a_end & w_end;
    assign sign_i = run & cfg_q.signed_a & a_end;
    assign sign_w = run & cfg_q.signed_w & w_end;

endmodule

// File: rtl/sip_shift_acc.sv
// Sequences 2b chunk pairs of an activation x weight job and shift-accumulates the dot-stage partial sums.
// Result valid NA*NW cycles after start without stalls; i_InValid low stalls, i_Ready low holds the result.
module sip_shift_acc #(
    parameter int BITS_IN  = sip_shift_acc_pkg::BITS_SIP_DOT_ADDER,
    parameter int BITS_ACC = sip_shift_acc_pkg::BITS_ACC,
    parameter int BITS_IDX = sip_shift_acc_pkg::BITS_CHUNK_IDX
) (
    input  logic                       i_CLK,
    input  logic                       i_RSTn,
    input  logic                       i_Start,
    input  logic [1:0]                 i_PrecA,
    input  logic [1:0]                 i_PrecW,
    input  logic                       i_SignedA,
    input  logic                       i_SignedW,
    input  logic                       i_InValid,
    input  logic signed [BITS_IN-1:0]  i_PartSum,
    output logic [BITS_IDX-1:0]        o_ActSel,
    output logic [BITS_IDX-1:0]        o_WgtSel,
    output logic                       o_SignI,
    output logic                       o_SignW,
    output logic                       o_Busy,
    output logic                       o_Valid,
    input  logic                       i_Ready,
    output logic signed [BITS_ACC-1:0] o_Result
);

    import sip_shift_acc_pkg::*;

    state_t                     state;
    logic signed [BITS_ACC-1:0] acc;
    logic                       valid_q;
    logic                       run;
    logic                       load;
    logic                       adv;
    logic                       last;
    idx_t                       ia;
    idx_t                       iw;
    job_cfg_t                   job_cfg;
    logic [BITS_CHUNK_IDX+1:0]  shamt;
    logic signed [BITS_ACC-1:0] part_ext;
    logic signed [BITS_ACC-1:0] addend;

    assign run  = (state == ST_RUN);
    assign load = (state == ST_IDLE) & i_Start;
    assign adv  = run & i_InValid;

    assign job_cfg.last_a   = prec_last_idx(i_PrecA);
    assign job_cfg.last_w   = prec_last_idx(i_PrecW);
    assign job_cfg.signed_a = i_SignedA;
    assign job_cfg.signed_w = i_SignedW;

    sip_step_ctr u_step_ctr (
        .core_clk (i_CLK),
        .arst_n   (i_RSTn),
        .load     (load),
        .cfg      (job_cfg),
        .run      (run),
        .adv      (adv),
        .ia       (ia),
        .iw       (iw),
        .last     (last),
        .sign_i   (o_SignI),
        .sign_w   (o_SignW)
    );

    // Chunk pair (ia, iw) carries weight 4^(ia+iw); shift is at most 12.
    assign shamt    = {({1'b0, ia} + {1'b0, iw}), 1'b0};
    assign part_ext = {{(BITS_ACC-BITS_IN){i_PartSum[BITS_IN-1]}}, i_PartSum};
    assign addend   = part_ext <<< shamt;

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            state   <= ST_IDLE;
            acc     <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_Start) begin
                        acc   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (i_InValid) begin
                        acc <= acc + addend;
                        if (last) begin
                            valid_q <= 1'b1;
                            state   <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (i_Ready) begin
                        valid_q <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_ActSel = BITS_IDX'(ia);
    assign o_WgtSel = BITS_IDX'(iw);
    assign o_Busy   = (state != ST_IDLE);
    assign o_Valid  = valid_q;
    assign o_Result = acc;

endmodule

// File: tb/tb_sip_shift_acc.sv
// Directed bench for sip_shift_acc: table of jobs with hand-computed results plus reset and backpressure sequences.
module tb_sip_shift_acc;

    localparam int BITS_IN  = 10;
    localparam int BITS_ACC = 32;
    localparam int BITS_IDX = 2;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b1;
    logic                       start = 1'b0;
    logic [1:0]                 prec_a = 2'd0;
    logic [1:0]                 prec_w = 2'd0;
    logic                       signed_a = 1'b0;
    logic                       signed_w = 1'b0;
    logic                       in_valid = 1'b0;
    logic signed [BITS_IN-1:0]  part_sum = '0;
    logic [BITS_IDX-1:0]        act_sel;
    logic [BITS_IDX-1:0]        wgt_sel;
    logic                       sign_i;
    logic                       sign_w;
    logic                       busy;
    logic                       valid;
    logic                       ready = 1'b0;
    logic signed [BITS_ACC-1:0] result;

    always #5 clk = ~clk;

    sip_shift_acc #(
        .BITS_IN  (BITS_IN),
        .BITS_ACC (BITS_ACC),
        .BITS_IDX (BITS_IDX)
    ) dut (
        .i_CLK     (clk),
        .i_RSTn    (rst_n),
        .i_Start   (start),
        .i_PrecA   (prec_a),
        .i_PrecW   (prec_w),
        .i_SignedA (signed_a),
        .i_SignedW (signed_w),
        .i_InValid (in_valid),
        .i_PartSum (part_sum),
        .o_ActSel  (act_sel),
        .o_WgtSel  (wgt_sel),
        .o_SignI   (sign_i),
        .o_SignW   (sign_w),
        .o_Busy    (busy),
        .o_Valid   (valid),
        .i_Ready   (ready),
        .o_Result  (result)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    typedef struct {
        string      name;
        logic [1:0] pa;
        logic [1:0] pw;
        logic       sa;
        logic       sw;
        logic [159:0] ps;
        int         stall_at;
        int         rdy_wait;
        int         exp;
    } vec_t;

    function automatic logic [159:0] rep(input int val);
        logic [159:0] v;
        logic [9:0]   s;
        s = val[9:0];
        v = '0;
        for (int k = 0; k < 16; k++) v[k*10 +: 10] = s;
        return v;
    endfunction

    function automatic int nchunks(input logic [1:0] p);
        return (p == 2'd0) ? 1 : (p == 2'd1) ? 2 : 4;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_actsel"}, int'(act_sel), 0);
        check({tag, "_wgtsel"}, int'(wgt_sel), 0);
        check({tag, "_signi"},  int'(sign_i), 0);
        check({tag, "_signw"},  int'(sign_w), 0);
    endtask

    task automatic run_job(input vec_t v);
        int na, nw, step, running, p;
        logic [9:0] raw;
        na = nchunks(v.pa);
        nw = nchunks(v.pw);
        step = 0;
        running = 0;
        @(negedge clk);
        prec_a = v.pa; prec_w = v.pw; signed_a = v.sa; signed_w = v.sw;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        prec_a = 2'd0; prec_w = 2'd0; signed_a = 1'b0; signed_w = 1'b0;
        check({v.name, "_busy_run"}, int'(busy), 1);
        for (int iw = 0; iw < nw; iw++) begin
            for (int ia = 0; ia < na; ia++) begin
                if (step == v.stall_at) begin
                    for (int s = 0; s < 3; s++) begin
                        in_valid = 1'b0;
                        part_sum = 10'sd100;
                        @(negedge clk);
                        check({v.name, "_stall_ia"},  int'(act_sel), ia);
                        check({v.name, "_stall_iw"},  int'(wgt_sel), iw);
                        check({v.name, "_stall_acc"}, int'(result), running);
                        check({v.name, "_stall_sw"},  int'(sign_w), int'(v.sw && iw == nw-1));
                    end
                end
                raw = v.ps[step*10 +: 10];
                in_valid = 1'b1;
                part_sum = raw;
                #1;
                check({v.name, "_actsel"}, int'(act_sel), ia);
                check({v.name, "_wgtsel"}, int'(wgt_sel), iw);
                check({v.name, "_signi"},  int'(sign_i), int'(v.sa && ia == na-1));
                check({v.name, "_signw"},  int'(sign_w), int'(v.sw && iw == nw-1));
                check({v.name, "_acc"},    int'(result), running);
                check({v.name, "_novalid"}, int'(valid), 0);
                p = int'($signed(raw));
                running = running + (p <<< (2*(ia+iw)));
                step++;
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        part_sum = '0;
        check({v.name, "_latency"}, int'(valid), 1);
        if (valid !== 1'b1) begin
            for (int w = 0; w < 20 && valid !== 1'b1; w++) @(negedge clk);
        end
        check({v.name, "_result"}, int'(result), v.exp);
        check_idle_outputs({v.name, "_done"});
        for (int k = 0; k < v.rdy_wait; k++) begin
            ready = 1'b0;
            start = (k == 2);
            @(negedge clk);
            check({v.name, "_hold_valid"},  int'(valid), 1);
            check({v.name, "_hold_result"}, int'(result), v.exp);
        end
        ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        start = 1'b0;
        check({v.name, "_valid_fall"}, int'(valid), 0);
        check({v.name, "_idle_busy"},  int'(busy), 0);
        check({v.name, "_retain"},     int'(result), v.exp);
        @(negedge clk);
        check({v.name, "_start_ign"},  int'(busy), 0);
        check_idle_outputs({v.name, "_idle"});
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{"s2x2",    2'd0, 2'd0, 1'b1, 1'b1, rep(-7), -1, 0, -7};
        vecs[1] = '{"s4x4",    2'd1, 2'd1, 1'b1, 1'b1,
                    {120'd0, 10'd1, 10'd5, 10'h3FE, 10'd3}, -1, 0, 31};
        vecs[2] = '{"u8xs2",   2'd2, 2'd0, 1'b0, 1'b1, rep(1), -1, 0, 85};
        vecs[3] = '{"u2xr8",   2'd0, 2'd3, 1'b0, 1'b0, rep(2), -1, 0, 170};
        vecs[4] = '{"s4xu2",   2'd1, 2'd0, 1'b1, 1'b0,
                    {140'd0, 10'h3FF, 10'd511}, -1, 0, 507};
        vecs[5] = '{"s4x4bp",  2'd1, 2'd1, 1'b1, 1'b1,
                    {120'd0, 10'd1, 10'd5, 10'h3FE, 10'd3}, 2, 5, 31};
        vecs[6] = '{"s8x8",    2'd2, 2'd2, 1'b1, 1'b1, rep(-512), -1, 0, -3699200};

        #2 rst_n = 1'b0;
        #1;
        check("rst_busy",   int'(busy), 0);
        check("rst_valid",  int'(valid), 0);
        check("rst_result", int'(result), 0);
        check_idle_outputs("rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_job(vecs[i]);

        // Abort an 8b x 8b job part way with an asynchronous reset.
        @(negedge clk);
        prec_a = 2'd2; prec_w = 2'd2; signed_a = 1'b1; signed_w = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1;
        part_sum = 10'sd3;
        repeat (5) @(negedge clk);
        check("abort_midrun_busy", int'(busy), 1);
        check("abort_midrun_ia",   int'(act_sel), 1);
        check("abort_midrun_iw",   int'(wgt_sel), 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy",   int'(busy), 0);
        check("abort_valid",  int'(valid), 0);
        check("abort_result", int'(result), 0);
        check_idle_outputs("abort");
        in_valid = 1'b0;
        part_sum = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_still_idle", int'(busy), 0);
        check("abort_no_valid",   int'(valid), 0);

        run_job(vecs[1]);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sip_shift_acc.md
Name: sip_shift_acc

Overview:
- Temporal shift-accumulate stage directly downstream of the 32-lane 2b×2b dot-adder.
- Sequences the 2-bit chunk pairs of a 2/4/8-bit activation × weight job.
- Drives the chunk selects and sign flags back to the dot stage.
- Sign-extends and shifts each signed partial sum by 2·(ia+iw), accumulates it, and presents the final dot product with a valid/ready handshake.

Parameters:
- BITS_IN, 10, width of signed partial sum from dot-adder (= `BITS_SIP_DOT_ADDER`)
- BITS_ACC, 32, signed accumulator/result width
- BITS_IDX, 2, width of chunk index (max 4 chunks per operand)

Ports:
- i_CLK  input  1  clock
- i_RSTn  input  1  asynchronous active-low reset
- i_Start  input  1  one-cycle job request; accepted only in IDLE
- i_PrecA  input  2  activation precision code: 0=2b, 1=4b, 2=8b, 3=reserved (treated as 8b)
- i_PrecW  input  2  weight precision code, same encoding
- i_SignedA  input  1  activations are signed
- i_SignedW  input  1  weights are signed
- i_InValid  input  1  i_PartSum valid for the current step
- i_PartSum  input  BITS_IN  signed partial sum for the current chunk pair
- o_ActSel  output  BITS_IDX  activation chunk index ia for the current step
- o_WgtSel  output  BITS_IDX  weight chunk index iw for the current step
- o_SignI  output  1  dot-stage SignI for the current step
- o_SignW  output  1  dot-stage SignW for the current step
- o_Busy  output  1  high in RUN and DONE
- o_Valid  output  1  result valid
- i_Ready  input  1  consumer accepts result
- o_Result  output  BITS_ACC  signed accumulated dot product

Behaviour:
- Reset (async, i_RSTn=0): state IDLE; all outputs and internal registers 0. Reset mid-job aborts with no output.
- Chunk counts:
  - NA = 1/2/4 for i_PrecA = 0/1/2 (3 → 4); NW likewise from i_PrecW.
  - Both counts and both signed flags are latched at start.
  - Total steps = NA·NW, range 1..16.
- State IDLE:
  - i_Start=1 → clear acc, ia=iw=0, latch config, go to RUN.
  - i_Start is ignored in any other state.
- State RUN:
  - Step order: ia inner, iw outer.
  - o_ActSel=ia, o_WgtSel=iw.
  - o_SignI = SignedA & (ia==NA-1); o_SignW = SignedW & (iw==NW-1).
  - The dot stage is combinational, so i_PartSum belongs to the currently driven step in the same cycle.
  - i_InValid=1: acc += sext(i_PartSum) <<< 2·(ia+iw), then advance the step. On the last step (ia==NA-1 and iw==NW-1) go to DONE.
  - i_InValid=0: stall; indices, acc and sign flags hold.
- Arithmetic: two's complement throughout; sext to BITS_ACC before the shift; wraps modulo 2^BITS_ACC with no saturation. Maximum shift is 12.
- State DONE:
  - o_Valid=1, o_Result=acc, held stable until i_Ready=1.
  - On the handshake → IDLE; o_Valid falls next cycle.
  - An i_Start in that same handshake cycle is ignored.
- Latency: a job with NA·NW steps and no stalls raises o_Valid exactly NA·NW cycles after the i_Start cycle.
- Outside RUN: o_ActSel, o_WgtSel, o_SignI and o_SignW are 0.
- o_Result retains its last value in IDLE.

Decomposition:
- Shared parameters include: BITS_SIP_DOT_ADDER, BITS_ACC, precision-code localparams (PREC_2B/4B/8B), and state encodings (IDLE/RUN/DONE).
- Sub-module: sip_step_ctr, which holds the ia/iw nested counter, last-step detect and sign-flag generation.
- The accumulator datapath stays in the top module.

Test Plan:
- Reset: assert i_RSTn=0 mid-RUN of an 8b×8b job → all outputs 0 asynchronously, state IDLE; after release, i_Start works normally.
- 2b×2b signed: i_Start, i_PartSum=-7 with i_InValid=1 → o_SignI=o_SignW=1 during the step; o_Valid next cycle with o_Result=-7.
- 4b×4b signed:
  - Steps (ia,iw) = (0,0),(1,0),(0,1),(1,1) with partial sums 3,-2,5,1 → result 3 − 8 + 20 + 16 = 31.
  - o_SignI high only when ia=1; o_SignW high only when iw=1.
- 8b×2b unsigned act, signed weight:
  - Four steps, each partial sum 1 → result 1+4+16+64 = 85.
  - o_SignI never high; o_SignW high on every step.
- Stall and backpressure:
  - Insert i_InValid=0 for 3 cycles mid-job → indices and acc hold; final result unchanged versus the no-stall run.
  - Hold i_Ready=0 for 5 cycles → o_Valid and o_Result stable; a pulsed i_Start is ignored.
- 8b×8b wrap: all 16 steps with i_PartSum=-512 → result = −512·Σ4^(ia+iw) = −512·7225 = −3699200; confirm the step ordering of o_ActSel/o_WgtSel.
